// File: rtl/wb_ddr3_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_ddr3_arbiter_if
// Bus bundle between NUM_MASTERS Wishbone masters, the round-robin arbiter
// and the single DDR3 controller Wishbone slave port.
//
// Signals (named from the arbiter's point of view):
//   i_m_adr/i_m_dat/i_m_sel   packed per-master address, write data, selects
//                             (slice i belongs to master i)
//   i_m_we/i_m_cyc/i_m_stb    per-master Wishbone controls
//   o_m_rdt                   read data broadcast to all masters
//   o_m_ack/o_m_err           per-master ack / error (owner bit only)
//   o_s_*                     request side towards the DDR3 slave
//   i_s_rdt/i_s_ack/i_s_err   response side from the DDR3 slave
//   o_grant                   registered one-hot owner
//
// Modports:
//   slave  - used by the arbiter (receives master requests, drives slave bus)
//   master - used by the environment around the arbiter (masters + slave)
// ---------------------------------------------------------------------------
interface wb_ddr3_arbiter_if #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32
);
    logic [NUM_MASTERS*AW-1:0]     i_m_adr;
    logic [NUM_MASTERS*DW-1:0]     i_m_dat;
    logic [NUM_MASTERS*DW/8-1:0]   i_m_sel;
    logic [NUM_MASTERS-1:0]        i_m_we;
    logic [NUM_MASTERS-1:0]        i_m_cyc;
    logic [NUM_MASTERS-1:0]        i_m_stb;
    logic [DW-1:0]                 o_m_rdt;
    logic [NUM_MASTERS-1:0]        o_m_ack;
    logic [NUM_MASTERS-1:0]        o_m_err;
    logic [AW-1:0]                 o_s_adr;
    logic [DW-1:0]                 o_s_dat;
    logic [DW/8-1:0]               o_s_sel;
    logic                          o_s_we;
    logic                          o_s_cyc;
    logic                          o_s_stb;
    logic [DW-1:0]                 i_s_rdt;
    logic                          i_s_ack;
    logic                          i_s_err;
    logic [NUM_MASTERS-1:0]        o_grant;

    modport slave (
        input  i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_m_stb,
        input  i_s_rdt, i_s_ack, i_s_err,
        output o_m_rdt, o_m_ack, o_m_err,
        output o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb,
        output o_grant
    );

    modport master (
        output i_m_adr, i_m_dat, i_m_sel, i_m_we, i_m_cyc, i_m_stb,
        output i_s_rdt, i_s_ack, i_s_err,
        input  o_m_rdt, o_m_ack, o_m_err,
        input  o_s_adr, o_s_dat, o_s_sel, o_s_we, o_s_cyc, o_s_stb,
        input  o_grant
    );
endinterface

// File: rtl/wb_ddr3_arbiter.sv
// ---------------------------------------------------------------------------
// wb_ddr3_arbiter
// Round-robin Wishbone arbiter sharing the DDR3 controller slave port among
// NUM_MASTERS requesters. Ownership lasts a whole cyc tenure, so bursts are
// never interleaved; one dead cycle separates consecutive tenures.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (released synchronously inside)
//   bus      wb_ddr3_arbiter_if.slave: master requests, slave bus, o_grant
//
// Optional feature (macro WB_ARB_WATCHDOG_EN):
//   defined     - watchdog counts stalled strobe cycles; at TIMEOUT it pulses
//                 the owner's err for one cycle and enters ABORT, which hides
//                 cyc/stb from the slave until the owner drops cyc.
//   not defined - no watchdog; a stalled slave hangs its owner.
// ---------------------------------------------------------------------------
module wb_ddr3_arbiter #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    wb_ddr3_arbiter_if.slave        bus
);

    localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam int SW     = DW / 8;
    localparam logic [IDX_W1-1:0] NM_C       = IDX_W1'(NUM_MASTERS);
    localparam logic [IDX_W-1:0]  LAST_RST_C = IDX_W'(NUM_MASTERS - 1);

`ifdef WB_ARB_WATCHDOG_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_OWN   = 2'b01,
        ST_ABORT = 2'b10
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;
`endif

    logic [1:0]             rst_sync_r;
    logic                   rst_core_n_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [NUM_MASTERS-1:0] grant_nxt_s;
    logic [IDX_W-1:0]       own_r;
    logic [IDX_W-1:0]       own_nxt_s;
    logic [IDX_W-1:0]       last_r;
    logic [IDX_W-1:0]       last_nxt_s;
    logic                   win_found_s;
    logic [IDX_W-1:0]       win_idx_s;
    logic [IDX_W1-1:0]      sum_s;
    logic [IDX_W1-1:0]      cand_s;
    logic                   hit_s;
    logic                   owner_cyc_s;
    logic                   own_act_s;
    logic                   s_stb_s;
    logic                   timeout_s;

    // Reset synchronizer: assertion is immediate, release waits two clock edges
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_core_n_s = rst_sync_r[1];

    // Round-robin search starting just after the last winner, wrapping around
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        sum_s       = '0;
        cand_s      = '0;
        hit_s       = 1'b0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            sum_s       = {1'b0, last_r} + IDX_W1'(k);
            cand_s      = (sum_s >= NM_C) ? (sum_s - NM_C) : sum_s;
            hit_s       = !win_found_s && bus.i_m_cyc[cand_s[IDX_W-1:0]];
            win_idx_s   = hit_s ? cand_s[IDX_W-1:0] : win_idx_s;
            win_found_s = win_found_s | hit_s;
        end
    end

    assign owner_cyc_s = bus.i_m_cyc[own_r];
    assign own_act_s   = (state_r == ST_OWN);
    assign s_stb_s     = own_act_s & owner_cyc_s & bus.i_m_stb[own_r];

`ifdef WB_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIM_C = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_cnt_r;

    assign timeout_s = s_stb_s && !(bus.i_s_ack || bus.i_s_err) && (wd_cnt_r == WD_LIM_C);

    // Watchdog: counts stalled strobe cycles of the current owner
    always_ff @(posedge i_clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            wd_cnt_r <= '0;
        end else if (!own_act_s || bus.i_s_ack || bus.i_s_err || timeout_s) begin
            wd_cnt_r <= '0;
        end else if (s_stb_s) begin
            wd_cnt_r <= wd_cnt_r + WD_W'(1);
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State, grant, owner index and round-robin pointer registers
    always_ff @(posedge i_clk or negedge rst_core_n_s) begin
        if (!rst_core_n_s) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            own_r   <= '0;
            last_r  <= LAST_RST_C;
        end else begin
            state_r <= state_nxt_s;
            grant_r <= grant_nxt_s;
            own_r   <= own_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Next-state logic: grant on any request, release when owner drops cyc
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        own_nxt_s   = own_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_nxt_s = ST_OWN;
                    grant_nxt_s = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win_idx_s;
                    own_nxt_s   = win_idx_s;
                    last_nxt_s  = win_idx_s;
                end else begin
                    grant_nxt_s = '0;
                end
            end
            ST_OWN: begin
`ifdef WB_ARB_WATCHDOG_EN
                if (timeout_s) begin
                    state_nxt_s = ST_ABORT;
                end else if (!owner_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_OWN;
                end
`else
                if (!owner_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_OWN;
                end
`endif
            end
`ifdef WB_ARB_WATCHDOG_EN
            ST_ABORT: begin
                // Grant is held so no other master sneaks in before the
                // aborted owner has abandoned its cycle.
                if (!owner_cyc_s) begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = '0;
                end else begin
                    state_nxt_s = ST_ABORT;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = '0;
            end
        endcase
    end

    // Slave bus mux and response routing; everything is zero unless owned
    always_comb begin
        bus.o_m_rdt = bus.i_s_rdt;
        bus.o_grant = grant_r;
        if (own_act_s) begin
            bus.o_s_cyc = owner_cyc_s;
            bus.o_s_stb = s_stb_s;
            bus.o_s_adr = bus.i_m_adr[int'(own_r)*AW +: AW];
            bus.o_s_dat = bus.i_m_dat[int'(own_r)*DW +: DW];
            bus.o_s_sel = bus.i_m_sel[int'(own_r)*SW +: SW];
            bus.o_s_we  = bus.i_m_we[own_r];
            bus.o_m_ack = grant_r & {NUM_MASTERS{bus.i_s_ack}};
            bus.o_m_err = grant_r & {NUM_MASTERS{bus.i_s_err | timeout_s}};
        end else begin
            bus.o_s_cyc = 1'b0;
            bus.o_s_stb = 1'b0;
            bus.o_s_adr = '0;
            bus.o_s_dat = '0;
            bus.o_s_sel = '0;
            bus.o_s_we  = 1'b0;
            bus.o_m_ack = '0;
            bus.o_m_err = '0;
        end
    end

endmodule

// File: tb/tb_wb_ddr3_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_ddr3_arbiter
// Self-checking bench for wb_ddr3_arbiter with three masters. A table of
// per-cycle vectors covers arbitration order, single reads, fairness, burst
// hold and error routing; hand-written sequences cover reset mid-tenure and,
// when WB_ARB_WATCHDOG_EN is defined, the watchdog abort (TIMEOUT = 16).
// ---------------------------------------------------------------------------
module tb_wb_ddr3_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic [2:0] cyc;
        logic [2:0] stb;
        logic       ack;
        logic       err;
        logic [2:0] e_grant;
        logic [2:0] e_ack;
        logic [2:0] e_err;
        logic       e_scyc;
        logic       e_sstb;
        int         e_own;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    logic [31:0] adr_t [3];
    logic [31:0] dat_t [3];
    logic [3:0]  sel_t [3];
    logic [2:0]  we_v;

    always #5 clk = ~clk;

    wb_ddr3_arbiter_if #(.NUM_MASTERS(NM), .AW(AW), .DW(DW)) bus ();

    wb_ddr3_arbiter #(
        .NUM_MASTERS (NM),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (16)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] cyc, input logic [2:0] stb, input logic ack,
                       input logic err, input logic [2:0] g, input logic [2:0] a,
                       input logic [2:0] e, input logic sc, input logic ss, input int own);
        vec_t v;
        v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err;
        v.e_grant = g; v.e_ack = a; v.e_err = e;
        v.e_scyc = sc; v.e_sstb = ss; v.e_own = own;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [2:0] cyc, input logic [2:0] stb,
                         input logic ack, input logic err, input logic [31:0] rdt);
        bus.i_m_cyc = cyc;
        bus.i_m_stb = stb;
        bus.i_s_ack = ack;
        bus.i_s_err = err;
        bus.i_s_rdt = rdt;
    endtask

    initial begin
        logic [2:0]  oh;
        logic [2:0]  f_cyc;
        logic [31:0] rdt;
        logic [31:0] e_adr;
        logic [31:0] e_dat;
        logic [3:0]  e_sel;
        logic        e_we;
        logic [2:0]  errval;
        int          errcyc;
        logic        found;

        adr_t[0] = 32'h0000_00A0; adr_t[1] = 32'h0000_0100; adr_t[2] = 32'h0000_0200;
        dat_t[0] = 32'h1111_1111; dat_t[1] = 32'h2222_2222; dat_t[2] = 32'h3333_3333;
        sel_t[0] = 4'h1;          sel_t[1] = 4'h3;          sel_t[2] = 4'hF;
        we_v = 3'b101;
        bus.i_m_adr = {adr_t[2], adr_t[1], adr_t[0]};
        bus.i_m_dat = {dat_t[2], dat_t[1], dat_t[0]};
        bus.i_m_sel = {sel_t[2], sel_t[1], sel_t[0]};
        bus.i_m_we  = we_v;

        // ---- vector table ----
        // simultaneous requests after reset: 0 first, 2 two cycles after 0 drops
        add(3'b101, 3'b101, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        add(3'b101, 3'b101, 1'b1, 1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 0);
        add(3'b100, 3'b100, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 0);
        add(3'b100, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        add(3'b100, 3'b100, 1'b1, 1'b0, 3'b100, 3'b100, 3'b000, 1'b1, 1'b1, 2);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 1'b0, 1'b0, 2);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        // fairness: everyone requests, single-beat tenures, order 0,1,2,0,1,2
        add(3'b111, 3'b111, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        for (int r = 0; r < 2; r++) begin
            for (int m = 0; m < 3; m++) begin
                oh = 3'b001 << m;
                add(3'b111, 3'b111, 1'b1, 1'b0, oh, oh, 3'b000, 1'b1, 1'b1, m);
                add(3'b111 & ~oh, 3'b111 & ~oh, 1'b0, 1'b0, oh, 3'b000, 3'b000, 1'b0, 1'b0, m);
                f_cyc = (r == 1 && m == 2) ? 3'b000 : 3'b111;
                add(f_cyc, f_cyc, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
            end
        end
        // single read by master 1, slave acks two cycles after the grant
        add(3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        add(3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1);
        add(3'b010, 3'b010, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b1, 1'b1, 1);
        add(3'b010, 3'b010, 1'b1, 1'b0, 3'b010, 3'b010, 3'b000, 1'b1, 1'b1, 1);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        // burst hold: master 0 takes 4 beats while master 1 waits
        add(3'b011, 3'b011, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        for (int b = 0; b < 4; b++) begin
            add(3'b011, 3'b011, 1'b1, 1'b0, 3'b001, 3'b001, 3'b000, 1'b1, 1'b1, 0);
        end
        add(3'b010, 3'b010, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000, 1'b0, 1'b0, 0);
        add(3'b010, 3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);
        add(3'b010, 3'b010, 1'b0, 1'b1, 3'b010, 3'b000, 3'b010, 1'b1, 1'b1, 1);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000, 1'b0, 1'b0, 1);
        add(3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, -1);

        // ---- reset state, with every input active ----
        drive(3'b111, 3'b111, 1'b1, 1'b1, 32'hCAFE_F00D);
        #12;
        chk("rst grant", bus.o_grant, 3'b000);
        chk("rst s_cyc", bus.o_s_cyc, 1'b0);
        chk("rst s_stb", bus.o_s_stb, 1'b0);
        chk("rst s_adr", bus.o_s_adr, 32'h0);
        chk("rst s_dat", bus.o_s_dat, 32'h0);
        chk("rst s_sel", bus.o_s_sel, 4'h0);
        chk("rst s_we",  bus.o_s_we, 1'b0);
        chk("rst m_ack", bus.o_m_ack, 3'b000);
        chk("rst m_err", bus.o_m_err, 3'b000);
        chk("rst m_rdt", bus.o_m_rdt, 32'hCAFE_F00D);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // ---- apply table ----
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rdt = vecs[i].ack ? 32'hDEAD_BEEF : (32'h5A00_0000 + 32'(i));
            drive(vecs[i].cyc, vecs[i].stb, vecs[i].ack, vecs[i].err, rdt);
            #1;
            if (vecs[i].e_own >= 0) begin
                e_adr = adr_t[vecs[i].e_own];
                e_dat = dat_t[vecs[i].e_own];
                e_sel = sel_t[vecs[i].e_own];
                e_we  = we_v[vecs[i].e_own];
            end else begin
                e_adr = 32'h0; e_dat = 32'h0; e_sel = 4'h0; e_we = 1'b0;
            end
            chk($sformatf("row%0d grant", i), bus.o_grant, vecs[i].e_grant);
            chk($sformatf("row%0d m_ack", i), bus.o_m_ack, vecs[i].e_ack);
            chk($sformatf("row%0d m_err", i), bus.o_m_err, vecs[i].e_err);
            chk($sformatf("row%0d s_cyc", i), bus.o_s_cyc, vecs[i].e_scyc);
            chk($sformatf("row%0d s_stb", i), bus.o_s_stb, vecs[i].e_sstb);
            chk($sformatf("row%0d s_adr", i), bus.o_s_adr, e_adr);
            chk($sformatf("row%0d s_dat", i), bus.o_s_dat, e_dat);
            chk($sformatf("row%0d s_sel", i), bus.o_s_sel, e_sel);
            chk($sformatf("row%0d s_we", i),  bus.o_s_we, e_we);
            chk($sformatf("row%0d m_rdt", i), bus.o_m_rdt, rdt);
        end

        // ---- reset while master 2 owns the slave ----
        @(negedge clk);
        drive(3'b100, 3'b100, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_grant == 3'b100) break;
        end
        chk("rstmid pre grant", bus.o_grant, 3'b100);
        bus.i_s_ack = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid grant", bus.o_grant, 3'b000);
        chk("rstmid s_cyc", bus.o_s_cyc, 1'b0);
        chk("rstmid s_stb", bus.o_s_stb, 1'b0);
        chk("rstmid m_ack", bus.o_m_ack, 3'b000);
        drive(3'b101, 3'b101, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_grant != 3'b000) break;
        end
        chk("rstmid post grant", bus.o_grant, 3'b001);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        repeat (3) @(negedge clk);

`ifdef WB_ARB_WATCHDOG_EN
        // ---- watchdog: slave never answers master 1 ----
        drive(3'b010, 3'b010, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_s_stb) begin
                found = 1'b1;
                break;
            end
        end
        chk("wd stb seen", found, 1'b1);
        errcyc = -1;
        errval = 3'b000;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            #1;
            if (bus.o_m_err != 3'b000) begin
                errcyc = k;
                errval = bus.o_m_err;
                break;
            end
        end
        chk("wd err cycle", 64'(errcyc), 64'd16);
        chk("wd err owner", errval, 3'b010);
        @(negedge clk);
        bus.i_s_ack = 1'b1;
        #1;
        chk("wd abort s_cyc", bus.o_s_cyc, 1'b0);
        chk("wd abort s_stb", bus.o_s_stb, 1'b0);
        chk("wd abort grant", bus.o_grant, 3'b010);
        chk("wd abort late ack", bus.o_m_ack, 3'b000);
        chk("wd abort err", bus.o_m_err, 3'b000);
        @(negedge clk);
        drive(3'b000, 3'b000, 1'b0, 1'b0, 32'h0);
        #1;
        chk("wd abort hold", bus.o_grant, 3'b010);
        @(negedge clk);
        #1;
        chk("wd idle grant", bus.o_grant, 3'b000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_ddr3_arbiter.md
# wb_ddr3_arbiter

Round-robin Wishbone arbiter that shares the single DDR3 controller Wishbone slave port in DecaSoc among `NUM_MASTERS` requesters (CPU instruction bus, CPU data bus, HDMI framebuffer reader). Ownership lasts for a whole `cyc` tenure, so bursts are never interleaved. An optional watchdog aborts stalled slave transactions.

## Interface
- `NUM_MASTERS`, 3: number of requesting masters (2..8); master index = slice index.
- `AW`, 32: address width.
- `DW`, 32: data width; select width is `DW/8`.
- `TIMEOUT`, 1024: stalled-strobe cycle limit (watchdog builds only).

Ports:
- `i_clk`  in  1  system clock; the block's only clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_m_adr`  in  NUM_MASTERS*AW  master addresses, slice i = master i.
- `i_m_dat`  in  NUM_MASTERS*DW  master write data.
- `i_m_sel`  in  NUM_MASTERS*DW/8  master byte selects.
- `i_m_we`, `i_m_cyc`, `i_m_stb`  in  NUM_MASTERS  per-master Wishbone controls.
- `o_m_rdt`  out  DW  read data, broadcast to all masters.
- `o_m_ack`, `o_m_err`  out  NUM_MASTERS  per-master ack and error; only the owner's bit can be high.
- `o_s_adr`/`o_s_dat`/`o_s_sel`/`o_s_we`/`o_s_cyc`/`o_s_stb`  out  AW/DW/DW/8/1/1/1  to the DDR3 slave.
- `i_s_rdt`  in  DW  slave read data.
- `i_s_ack`, `i_s_err`  in  1  slave ack and error.
- `o_grant`  out  NUM_MASTERS  one-hot owner, registered; all zeros when idle.

## Operation
- States:
  - IDLE: no owner.
  - OWN: one master owns the slave.
  - ABORT: watchdog recovery (watchdog builds only).
- IDLE → OWN: any `i_m_cyc` high. The winner is the first requester searched from `last+1` upward, wrapping modulo NUM_MASTERS. `o_grant` and `last` load the winner index.
- OWN:
  - The slave bus is muxed combinationally from the owner: `o_s_cyc = cyc[own]`, `o_s_stb = cyc[own] & stb[own]`; `o_s_adr`/`o_s_dat`/`o_s_sel`/`o_s_we` follow the owner's slice.
  - `i_s_ack`/`i_s_err` route only to `o_m_ack[own]`/`o_m_err[own]`.
  - `o_m_rdt = i_s_rdt` always.
- OWN → IDLE: owner `cyc` low, sampled at a clock edge. `o_grant` clears on that edge.
- Other masters' `cyc`/`stb` are ignored while OWN; a non-owner never sees `ack`/`err`.
- When no owner: `o_s_cyc`, `o_s_stb`, `o_s_we`, `o_s_adr`, `o_s_dat`, `o_s_sel` are all 0.
- Simultaneous requests: the round-robin order decides. After reset master 0 has highest priority (`last` resets to NUM_MASTERS-1).
- A master that keeps `cyc` high continuously keeps ownership indefinitely; fairness applies only at tenure boundaries.

## Timing
- Reset (asynchronous assert, synchronous to `i_clk` deassert internally):
  - state = IDLE, `o_grant` = 0, `last` = NUM_MASTERS-1, watchdog count = 0.
  - All slave outputs 0; all `o_m_ack`/`o_m_err` 0; `o_m_rdt` follows `i_s_rdt`.
- Grant latency: `cyc` high in cycle N gives `o_grant` and `o_s_cyc` in cycle N+1.
- Slave-to-master path: `ack`/`err` are combinational, zero added latency.
- Release: owner `cyc` low in cycle N puts the block in IDLE in N+1; a new grant appears in N+2. There is one dead cycle between tenures.
- Reset mid-transaction: the slave bus drops immediately and asynchronously. The masters are responsible for abandoning their cycles.

## Configuration
- `WB_ARB_WATCHDOG_EN` defined:
  - A counter increments each cycle in OWN with `o_s_stb` high and `i_s_ack | i_s_err` low, and clears on `ack`/`err` or when leaving OWN.
  - When the count reaches `TIMEOUT`, the block pulses `o_m_err[own]` for 1 cycle and enters ABORT.
  - ABORT forces `o_s_cyc`/`o_s_stb` to 0 and holds `o_grant`, for a minimum of 1 cycle, until owner `cyc` is low. It then returns to IDLE.
  - A late slave `ack` arriving during ABORT is dropped.
- `WB_ARB_WATCHDOG_EN` not defined: no counter and no ABORT state; a stalled slave hangs its owner forever.

## Test plan
- Single read: master 1 issues `cyc`/`stb` with `adr`=0x100; the slave acks 2 cycles later with `rdt`=0xDEADBEEF. Expect `o_grant`=3'b010 one cycle after `cyc`, `o_m_ack`=3'b010 only, and the master sees 0xDEADBEEF.
- Simultaneous requests after reset: masters 0 and 2 raise `cyc` in the same cycle. Expect master 0 granted first, then master 2 two cycles after master 0 drops `cyc`.
- Fairness: all three masters request continuously with single-beat tenures. Expect grant order 0,1,2,0,1,2.
- Burst hold: master 0 holds `cyc` across 4 stb/ack beats while master 1 requests. Expect master 1 sees no `ack`, `o_grant` stays 3'b001 for the whole burst, and master 1 is granted afterwards.
- Watchdog (`TIMEOUT`=16, macro defined): the slave never acks. Expect `o_m_err[own]` pulses exactly 16 cycles after `stb`, then `o_s_cyc`=0, then IDLE once the owner drops `cyc`.
- Reset mid-burst: assert `i_rst_n`=0 while master 2 owns the slave. Expect `o_grant`=0 and `o_s_cyc`=0 immediately; after release, master 0 wins first.
